// File: rtl/drum_track_access.sv
// Single-word read/write access to a serial recirculating drum track.
// Free-running bit/word counters locate the track head; the FSM seeks to the word, then shifts it.
module drum_track_access #(
    parameter int unsigned WORD_BITS = 29,
    parameter int unsigned WORDS     = 108
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 write,
    input  logic [6:0]           addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WORD_BITS-1:0] rdata,
    input  logic                 trk_dout,
    output logic                 trk_din,
    output logic [4:0]           bit_pos,
    output logic [6:0]           word_pos
);

    localparam int unsigned BW = 5;
    localparam int unsigned AW = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t               state, state_next;
    logic                 write_q;
    logic [AW-1:0]        addr_q;
    logic [WORD_BITS-1:0] wdata_q;
    logic                 accept;
    logic                 done_next;
    logic                 err_next;
    logic                 bit_wrap;
    logic [AW-1:0]        word_next;

    assign bit_wrap  = (bit_pos == BW'(WORD_BITS - 1));
    assign word_next = (word_pos == AW'(WORDS - 1)) ? '0 : word_pos + AW'(1);

    // Head position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_pos  <= '0;
            word_pos <= '0;
        end else if (bit_wrap) begin
            bit_pos  <= '0;
            word_pos <= word_next;
        end else begin
            bit_pos  <= bit_pos + BW'(1);
        end
    end

    // State register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= done_next;
            err   <= err_next;
        end
    end

    // Next-state and pulse decode; XFER is entered on the edge that lands on bit 0 of the target word
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (32'(addr) < WORDS) begin
                        accept     = 1'b1;
                        state_next = SEEK;
                    end else begin
                        err_next   = 1'b1;
                    end
                end
            end
            SEEK: begin
                if (bit_wrap && (word_next == addr_q)) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (bit_wrap) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= write;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Read shift: each XFER bit captures the old track bit, so writes return the overwritten word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (state == XFER) begin
            rdata[bit_pos] <= trk_dout;
        end
    end

    assign trk_din = ((state == XFER) && write_q) ? wdata_q[bit_pos] : trk_dout;

endmodule

// File: tb/tb_drum_track_access.sv
// Directed bench for drum_track_access with a behavioural 108x29 recirculating track model.
module tb_drum_track_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        write;
    logic [6:0]  addr;
    logic [28:0] wdata;
    logic        busy, done, err;
    logic [28:0] rdata;
    logic        trk_dout, trk_din;
    logic [4:0]  bit_pos;
    logic [6:0]  word_pos;
    logic        load;

    logic [28:0] mem  [0:107];
    logic [28:0] snap [0:107];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drum_track_access dut (
        .clk(clk), .rst_n(rst_n), .req(req), .write(write), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .trk_dout(trk_dout), .trk_din(trk_din), .bit_pos(bit_pos), .word_pos(word_pos)
    );

    // Track model: head reads the current cell and stores trk_din back into it each bit time
    always_comb trk_dout = mem[word_pos][bit_pos];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 108; i++) mem[i] <= 29'(i);
        end else begin
            mem[word_pos][bit_pos] <= trk_din;
        end
    end

    task automatic issue(input logic w, input logic [6:0] a, input logic [28:0] d);
        req = 1'b1; write = w; addr = a; wdata = d;
    endtask

    task automatic wait_pos(input int w, input int b, input int lim);
        int n = 0;
        while (!(int'(word_pos) == w && int'(bit_pos) == b) && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL wait_pos: position (%0d,%0d) not reached in %0d cycles", w, b, lim);
        end
    endtask

    task automatic wait_done(input bit hold, input int lim, output int n, output int ne, output logic b1);
        n = 0; ne = 0; b1 = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                b1 = busy;
                if (!hold) req = 1'b0;
            end
            if (err) ne++;
        end while (!done && n < lim);
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (rdata !== 29'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (bit_pos !== 5'd0) begin errors++; $display("FAIL reset_bit_pos: got %0d want 0", bit_pos); end
        checks++; if (word_pos !== 7'd0) begin errors++; $display("FAIL reset_word_pos: got %0d want 0", word_pos); end
        checks++; if (trk_din !== trk_dout) begin errors++; $display("FAIL reset_recirc: got %b want %b", trk_din, trk_dout); end
    endtask

    // Read word 5 requested at (0,0): XFER cycles 145..173, done in cycle 174
    task automatic test_read;
        int n, ne; logic b1;
        rst_n = 1'b1;
        issue(1'b0, 7'd5, 29'd0);
        checks++; if (bit_pos !== 5'd0 || word_pos !== 7'd0) begin
            errors++; $display("FAIL read_start_pos: got (%0d,%0d) want (0,0)", word_pos, bit_pos);
        end
        wait_done(1'b0, 400, n, ne, b1);
        checks++; if (n != 174) begin errors++; $display("FAIL read_latency: got %0d want 174", n); end
        checks++; if (rdata !== 29'd5) begin errors++; $display("FAIL read_rdata: got %h want 5", rdata); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL read_busy_after_accept: got %b want 1", b1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL read_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_write;
        int n, ne; logic b1;
        issue(1'b1, 7'd107, 29'h1ABCDEF0);
        wait_done(1'b0, 3300, n, ne, b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL write_done: got %b want 1", done); end
        checks++; if (rdata !== 29'd107) begin errors++; $display("FAIL write_old_value: got %h want 6b", rdata); end
        issue(1'b0, 7'd107, 29'd0);
        wait_done(1'b0, 3300, n, ne, b1);
        checks++; if (rdata !== 29'h1ABCDEF0) begin errors++; $display("FAIL write_readback: got %h want 1abcdef0", rdata); end
        checks++; if (mem[106] !== 29'd106) begin errors++; $display("FAIL write_word106: got %h want 6a", mem[106]); end
        checks++; if (mem[0] !== 29'd0) begin errors++; $display("FAIL write_word0: got %h want 0", mem[0]); end
        issue(1'b0, 7'd106, 29'd0);
        wait_done(1'b0, 3300, n, ne, b1);
        checks++; if (rdata !== 29'd106) begin errors++; $display("FAIL write_read106: got %h want 6a", rdata); end
    endtask

    task automatic test_err;
        int bad = 0, bz = 0, diff = 0;
        for (int i = 0; i < 108; i++) snap[i] = mem[i];
        issue(1'b1, 7'd108, 29'h1FFFFFFF);
        @(negedge clk);
        req = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", err); end
        issue(1'b1, 7'd127, 29'h1FFFFFFF);
        @(negedge clk);
        req = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_addr127: got %b want 1", err); end
        for (int i = 0; i < 3132; i++) begin
            @(negedge clk);
            if (busy) bz++;
            if (err || done) bad++;
        end
        checks++; if (bz != 0) begin errors++; $display("FAIL err_busy_rev: got %0d busy cycles want 0", bz); end
        checks++; if (bad != 0) begin errors++; $display("FAIL err_stray_pulses: got %0d want 0", bad); end
        for (int i = 0; i < 108; i++) if (mem[i] !== snap[i]) diff++;
        checks++; if (diff != 0) begin errors++; $display("FAIL err_track_changed: got %0d words differ want 0", diff); end
    endtask

    // Accept at (3,1) for word 3: XFER starts 3131 cycles later, done 29 cycles after that
    task automatic test_full_rev;
        int n, ne; logic b1;
        wait_pos(3, 1, 3200);
        issue(1'b0, 7'd3, 29'd0);
        wait_done(1'b0, 3300, n, ne, b1);
        checks++; if (n != 3160) begin errors++; $display("FAIL full_rev_latency: got %0d want 3160", n); end
        checks++; if (rdata !== 29'd3) begin errors++; $display("FAIL full_rev_rdata: got %h want 3", rdata); end
    endtask

    task automatic test_reset_mid_write;
        int n, ne; logic b1;
        wait_pos(50, 0, 3200);
        issue(1'b1, 7'd2, 29'h1FFFFFFF);
        @(negedge clk);
        req = 1'b0;
        wait_pos(2, 10, 3200);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (bit_pos !== 5'd0 || word_pos !== 7'd0) begin
            errors++; $display("FAIL rst_mid_counters: got (%0d,%0d) want (0,0)", word_pos, bit_pos);
        end
        checks++; if (trk_din !== trk_dout) begin errors++; $display("FAIL rst_mid_recirc: got %b want %b", trk_din, trk_dout); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after: got done=%b err=%b busy=%b want 0", done, err, busy);
        end
        checks++; if (mem[2] !== 29'h000007FF) begin errors++; $display("FAIL rst_mid_word2: got %h want 7ff", mem[2]); end
        checks++; if (mem[1] !== 29'd1 || mem[3] !== 29'd3) begin
            errors++; $display("FAIL rst_mid_neighbours: got %h %h want 1 3", mem[1], mem[3]);
        end
        issue(1'b0, 7'd2, 29'd0);
        wait_done(1'b0, 3300, n, ne, b1);
        checks++; if (rdata !== 29'h000007FF) begin errors++; $display("FAIL rst_mid_readback: got %h want 7ff", rdata); end
    endtask

    task automatic test_back_to_back;
        int n, ne; logic b1;
        issue(1'b0, 7'd10, 29'd0);
        @(negedge clk);
        addr = 7'd20;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_first: got %b want 1", busy); end
        wait_done(1'b1, 3300, n, ne, b1);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_done_cycle: got done=%b busy=%b want 1 0", done, busy);
        end
        checks++; if (rdata !== 29'd10) begin errors++; $display("FAIL b2b_rdata1: got %h want a", rdata); end
        checks++; if (ne != 0 || err !== 1'b0) begin errors++; $display("FAIL b2b_err_first: got %0d want 0", ne); end
        @(negedge clk);
        req = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL b2b_second_accept: got busy=%b done=%b err=%b want 1 0 0", busy, done, err);
        end
        wait_done(1'b0, 3300, n, ne, b1);
        checks++; if (rdata !== 29'd20) begin errors++; $display("FAIL b2b_rdata2: got %h want 14", rdata); end
        checks++; if (ne != 0) begin errors++; $display("FAIL b2b_err_second: got %0d want 0", ne); end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b1;
        req = 1'b0; write = 1'b0; addr = 7'd0; wdata = 29'd0;
        @(negedge clk);
        @(negedge clk);
        load = 1'b0;
        test_reset;
        test_read;
        test_write;
        test_err;
        test_full_rev;
        test_reset_mid_write;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
